// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
package riscv_ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned ALUCTL_W = 3;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [ALUCTL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctl_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Immediate format selected purely from the opcode, independent of state.
    function automatic imm_src_e imm_src_for(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/ALUDecoder.sv
// Maps ALUOp plus funct fields onto the ALU operation select.
module ALUDecoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_e                  alu_op_i,
    input  logic [FUNCT3_W-1:0]      funct3_i,
    input  logic                     funct7b5_i,
    input  logic                     op5_i,
    output logic [ALUCTL_W-1:0]      alu_control_o
);

    // Only R-type (op[5]=1) with funct7[5] set turns funct3=000 into sub.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (funct7b5_i && op5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM sequencing the shared-ALU, unified-memory RV32I datapath.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   zero_i,
    input  logic                   mem_ready_i,
    output logic                   MemReq_o,
    output logic                   MemWrite_o,
    output logic                   AdrSrc_o,
    output logic                   IRWrite_o,
    output logic                   PCWrite_o,
    output logic                   RegWrite_o,
    output logic [1:0]             ResultSrc_o,
    output logic [1:0]             ALUSrcA_o,
    output logic [1:0]             ALUSrcB_o,
    output logic [ALUCTL_W-1:0]    ALUControl_o,
    output logic [1:0]             ImmSrc_o,
    output logic                   retire_o,
    output logic                   halt_o
);

    state_e                state_q, state_d;
    logic [OPCODE_W-1:0]   opcode;
    logic [FUNCT3_W-1:0]   funct3;
    logic                  funct7b5;
    logic                  unused_instr_bits;

    logic        mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c;
    logic        reg_write_c, retire_c, halt_c;
    result_src_e result_src_c;
    src_a_e      src_a_c;
    src_b_e      src_b_c;
    alu_op_e     alu_op_c;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7b5 = instr_i[30];
    assign unused_instr_bits = ^{instr_i[INSTR_WIDTH-1:31], instr_i[29:15], instr_i[11:7]};

    // State register; reset drops back to FETCH and abandons any instruction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; Moore except the ready/zero gated terms.
    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        retire_c     = 1'b0;
        halt_c       = 1'b0;
        result_src_c = RES_ALUOUT;
        src_a_c      = SRCA_PC;
        src_b_c      = SRCB_RS2;
        alu_op_c     = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                mem_req_c    = 1'b1;
                src_a_c      = SRCA_PC;
                src_b_c      = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                if (mem_ready_i) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: begin
                src_a_c = SRCA_RS1;
                src_b_c = SRCB_IMM;
                state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready_i) state_d = MEMWB;
            end
            MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                retire_c     = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready_i) begin
                    retire_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            EXECR: begin
                src_a_c  = SRCA_RS1;
                src_b_c  = SRCB_RS2;
                alu_op_c = ALUOP_FUNCT;
                state_d  = ALUWB;
            end
            EXECI: begin
                src_a_c  = SRCA_RS1;
                src_b_c  = SRCB_IMM;
                alu_op_c = ALUOP_FUNCT;
                state_d  = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = FETCH;
            end
            BEQ: begin
                src_a_c    = SRCA_RS1;
                src_b_c    = SRCB_RS2;
                alu_op_c   = ALUOP_SUB;
                pc_write_c = zero_i;
                retire_c   = 1'b1;
                state_d    = FETCH;
            end
            JAL: begin
                src_a_c    = SRCA_OLDPC;
                src_b_c    = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_d    = ALUWB;
            end
            TRAP: begin
                halt_c = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    ALUDecoder u_alu_decoder (
        .alu_op_i      (alu_op_c),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (opcode[5]),
        .alu_control_o (ALUControl_o)
    );

    // Reset must silence every enable at once, even before the state flop settles.
    assign MemReq_o    = mem_req_c   & rst_n_i;
    assign MemWrite_o  = mem_write_c & rst_n_i;
    assign AdrSrc_o    = adr_src_c;
    assign IRWrite_o   = ir_write_c  & rst_n_i;
    assign PCWrite_o   = pc_write_c  & rst_n_i;
    assign RegWrite_o  = reg_write_c & rst_n_i;
    assign retire_o    = retire_c    & rst_n_i;
    assign halt_o      = halt_c      & rst_n_i;
    assign ResultSrc_o = result_src_c;
    assign ALUSrcA_o   = src_a_c;
    assign ALUSrcB_o   = src_b_c;
    assign ImmSrc_o    = imm_src_for(opcode);

endmodule
